// File: rtl/loba_dot_acc_if.sv
// Bundle of the product-in and result-out handshakes of the LOBA dot-product accumulator.
// slave is the accumulator side, master is the producer/consumer side.
interface loba_dot_acc_if #(
  parameter int N     = 16,
  parameter int ACC_W = 40,
  parameter int CNT_W = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [2*N-1:0]     in_p;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [ACC_W-1:0]   out_sum;
  logic [CNT_W-1:0]   out_count;
  logic               out_sat;

  modport slave (
    input  in_valid, in_p, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_sat
  );

  modport master (
    output in_valid, in_p, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_sat
  );
endinterface

// File: rtl/loba_dot_acc.sv
// Saturating streaming accumulator for LOBA multiplier products: sums one vector
// (terminated by in_last) and presents sum, term count and clip flag downstream.
module loba_dot_acc #(
  parameter int N     = 16,
  parameter int ACC_W = 40,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  loba_dot_acc_if.slave      bus,
  output logic [1:0]         dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int         PAD  = ACC_W + 1 - 2*N;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high. The producer holds in_p/in_last stable until accepted; the result stays
  // stable until out_ready is seen. in_ready depends on registered state only.

  logic [1:0]       state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             sat;
  logic [ACC_W-1:0] out_sum_r;
  logic [CNT_W-1:0] out_count_r;
  logic             out_sat_r;

  logic             beat;
  logic             out_hs;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] acc_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             sat_nxt;

  assign bus.in_ready  = (state != DONE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_sum   = out_sum_r;
  assign bus.out_count = out_count_r;
  assign bus.out_sat   = out_sat_r;
  assign dbg_state     = state;

  assign beat   = bus.in_valid && bus.in_ready;
  assign out_hs = bus.out_valid && bus.out_ready;

  // One extra bit catches the carry out; once clipped, all-ones plus any term
  // carries again, so the accumulator remains pinned for the rest of the vector.
  always_comb begin
    sum_ext = {1'b0, acc} + {{PAD{1'b0}}, bus.in_p};
    acc_nxt = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
    sat_nxt = sat | sum_ext[ACC_W];
    cnt_nxt = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      sat         <= 1'b0;
      out_sum_r   <= '0;
      out_count_r <= '0;
      out_sat_r   <= 1'b0;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (beat) begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
            sat <= sat_nxt;
            if (bus.in_last) begin
              state       <= DONE;
              out_sum_r   <= acc_nxt;
              out_count_r <= cnt_nxt;
              out_sat_r   <= sat_nxt;
            end else begin
              state <= ACC;
            end
          end
        end
        DONE: begin
          if (out_hs) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            sat   <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          acc   <= '0;
          cnt   <= '0;
          sat   <= 1'b0;
        end
      endcase
    end
  end

endmodule
